// File: rtl/henon_result_uart_tx.sv
// UART 8N1 transmitter returning the PRNG's Q1.31 x/y results to the host.
// A rising edge on result_valid captures both words and sends one frame: optional header, x MSB first, then y.
module henon_result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned HEADER_EN    = 1,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        result_valid,
    input  logic [31:0] result_x,
    input  logic [31:0] result_y,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic        dropped
);

    localparam int unsigned NBYTES    = (HEADER_EN != 0) ? 9 : 8;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned FRAME_W   = 72;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BYTE_LAST = 4'(NBYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [3:0]         byte_q, byte_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
    logic               valid_q;

    logic               edge_c;
    logic               baud_end_c;
    logic [63:0]        data_c;
    logic [FRAME_W-1:0] load_c;

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign dropped    = drop_q;

    assign edge_c     = result_valid & ~valid_q;
    assign baud_end_c = (baud_q == BAUD_LAST);

    // Frame buffer is shifted right one bit per data bit, so byte 0 sits in the low byte.
    assign data_c = {result_y[7:0], result_y[15:8], result_y[23:16], result_y[31:24],
                     result_x[7:0], result_x[15:8], result_x[23:16], result_x[31:24]};
    assign load_c = (HEADER_EN != 0) ? {data_c, HEADER_BYTE} : {8'h00, data_c};

    // State and output registers; valid_q resets high so a level held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            valid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            valid_q <= result_valid;
        end
    end

    // Next-state logic; an edge landing on the frame_done cycle counts as a collision.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = edge_c & ((state_q != S_IDLE) | done_q);

        case (state_q)
            S_IDLE: begin
                if (edge_c && !done_q) begin
                    frame_d = load_c;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = frame_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end_c) begin
                    baud_d  = '0;
                    frame_d = frame_q >> 1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = frame_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end_c) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_henon_result_uart_tx.sv
// Directed bench for henon_result_uart_tx: header (dut0) and header-less (dut1) instances share stimulus.
module tb_henon_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        result_valid = 1'b0;
    logic [31:0] result_x = 32'h12345678;
    logic [31:0] result_y = 32'h9ABCDEF0;
    logic        tx0, busy0, done0, drop0;
    logic        tx1, busy1, done1, drop1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_drop0 = 0;
    int n_done0 = 0;

    logic       sel = 1'b0;
    logic       tx_m, busy_m, done_m;
    logic [7:0] rx_bytes [9];
    logic [7:0] exp_b [9] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    int         rx_len, rx_frm_err, rx_busy_gap;
    logic       rx_ok;

    henon_result_uart_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1), .HEADER_BYTE(8'hA5)) dut0 (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid),
        .result_x(result_x), .result_y(result_y),
        .tx(tx0), .busy(busy0), .frame_done(done0), .dropped(drop0));

    henon_result_uart_tx #(.CLKS_PER_BIT(4), .HEADER_EN(0), .HEADER_BYTE(8'hA5)) dut1 (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid),
        .result_x(result_x), .result_y(result_y),
        .tx(tx1), .busy(busy1), .frame_done(done1), .dropped(drop1));

    always #5 clk = ~clk;

    assign tx_m   = sel ? tx1   : tx0;
    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (drop0 === 1'b1) n_drop0 <= n_drop0 + 1;
        if (done0 === 1'b1) n_done0 <= n_done0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (busy_m !== 1'b1 && done_m !== 1'b1) rx_busy_gap++;
        end
    endtask

    task automatic pulse();
        @(negedge clk) result_valid = 1'b1;
        @(negedge clk) result_valid = 1'b0;
    endtask

    // Samples the selected line at bit centres (2 cycles into each 4-cycle bit).
    task automatic capture(input int nb);
        int i;
        int t0;
        rx_ok = 1'b0; rx_frm_err = 0; rx_busy_gap = 0; rx_len = -1;
        for (int k = 0; k < 9; k++) rx_bytes[k] = 8'h00;
        i = 0;
        while (tx_m !== 1'b0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (tx_m !== 1'b0) return;
        rx_ok = 1'b1;
        t0 = cyc;
        step(2);
        for (int j = 0; j < 10 * nb; j++) begin
            if (j > 0) step(4);
            if (j % 10 == 0) begin
                if (tx_m !== 1'b0) rx_frm_err++;
            end else if (j % 10 == 9) begin
                if (tx_m !== 1'b1) rx_frm_err++;
            end else begin
                rx_bytes[j / 10][(j % 10) - 1] = tx_m;
            end
        end
        i = 0;
        while (done_m !== 1'b1 && i < 20) begin
            step(1);
            i++;
        end
        if (done_m === 1'b1) rx_len = cyc - t0;
    endtask

    task automatic check_frame(input string tag, input int nb);
        int off;
        off = (nb == 9) ? 0 : 1;
        check({tag, "_start"}, 32'(rx_ok), 32'd1);
        check({tag, "_framing"}, 32'(rx_frm_err), 32'd0);
        for (int k = 0; k < nb; k++)
            check($sformatf("%s_byte%0d", tag, k), 32'(rx_bytes[k]), 32'(exp_b[k + off]));
        check({tag, "_len"}, 32'(rx_len), 32'(nb * 40));
        check({tag, "_busy_gap"}, 32'(rx_busy_gap), 32'd0);
    endtask

    initial begin
        bit hi_seen;
        int i;

        // Reset with result_valid already high
        result_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_drop", 32'(drop0), 32'd0);
        rst_n = 1'b1;
        hi_seen = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || tx1 !== 1'b1) hi_seen = 1'b0;
        end
        check("level_at_release_no_frame", 32'(hi_seen), 32'd1);
        result_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Header frame on dut0
        sel = 1'b0;
        pulse();
        capture(9);
        check_frame("hdr", 9);
        repeat (60) @(negedge clk);

        // Header-less frame on dut1
        sel = 1'b1;
        pulse();
        capture(8);
        check_frame("nohdr", 8);
        repeat (100) @(negedge clk);

        // Second edge 50 cycles into a frame is dropped
        sel = 1'b0;
        n_drop0 = 0;
        pulse();
        fork
            capture(9);
            begin
                repeat (50) @(negedge clk);
                result_x = 32'hFFFFFFFF;
                pulse();
                result_x = 32'h12345678;
            end
        join
        check_frame("drop", 9);
        check("drop_count", 32'(n_drop0), 32'd1);
        repeat (100) @(negedge clk);

        // Level held high for 2000 cycles sends one frame
        n_drop0 = 0;
        n_done0 = 0;
        @(negedge clk) result_valid = 1'b1;
        repeat (2000) @(negedge clk);
        result_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("hold_frames", 32'(n_done0), 32'd1);
        check("hold_drops", 32'(n_drop0), 32'd0);

        // Reset 100 cycles into a frame
        pulse();
        repeat (100) @(negedge clk);
        check("pre_abort_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx0), 32'd1);
        check("abort_busy", 32'(busy0), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_abort_tx", 32'(tx0), 32'd1);
        pulse();
        capture(9);
        check_frame("after_abort", 9);

        // Edge on the frame_done cycle is dropped; one cycle later it is accepted
        repeat (60) @(negedge clk);
        n_drop0 = 0;
        pulse();
        i = 0;
        while (done0 !== 1'b1 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("b2b_done_seen", 32'(done0), 32'd1);
        result_valid = 1'b1;
        @(negedge clk);
        check("b2b_drop_pulse", 32'(drop0), 32'd1);
        check("b2b_not_busy", 32'(busy0), 32'd0);
        result_valid = 1'b0;
        hi_seen = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx0 !== 1'b1) hi_seen = 1'b0;
        end
        check("b2b_no_frame", 32'(hi_seen), 32'd1);
        pulse();
        check("b2b_later_accept", 32'(busy0), 32'd1);
        check("b2b_later_tx", 32'(tx0), 32'd0);
        check("b2b_drop_count", 32'(n_drop0), 32'd1);
        repeat (400) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
